// File: rtl/psoa_sigmoid_pkg.sv
// Shared fixed-point types and constants for the signed sigmoid stage and its unsigned core.
package psoa_sigmoid_pkg;

   typedef logic signed [15:0] fix16_s_t;
   typedef logic [15:0]        fix16_u_t;

   localparam int       FRAC_BITS   = 10;
   localparam fix16_u_t ONE_Q10     = 16'd1024;
   localparam fix16_u_t MAX_ABS_DEF = 16'd8191;

endpackage

// File: rtl/psoa_sigmoid.sv
// Unsigned Q6.10 sigmoid core: piecewise-linear approximation, LAT register stages, no stall.
module psoa_sigmoid
   import psoa_sigmoid_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic [15:0] x,
   output logic [15:0] f_x
);

   fix16_u_t f_c;
   fix16_u_t pipe [LAT];

   // Segments break at 1.0, 2.375 and 5.0; slopes are powers of two so shifts suffice.
   always_comb begin
      f_c = ONE_Q10;
      if (x >= 16'd5120) begin
         f_c = ONE_Q10;
      end else if (x >= 16'd2432) begin
         f_c = (x >> 5) + 16'd864;
      end else if (x >= 16'd1024) begin
         f_c = (x >> 3) + 16'd640;
      end else begin
         f_c = (x >> 2) + 16'd512;
      end
   end

   always_ff @(posedge clk) begin
      pipe[0] <= f_c;
      for (int i = 1; i < LAT; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign f_x = pipe[LAT-1];

endmodule

// File: rtl/psoa_sym_fifo.sv
// Synchronous FIFO with a registered head word (dout is not fall-through).
module psoa_sym_fifo
   import psoa_sigmoid_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_nxt;

   assign rd_nxt = rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // The head register reloads from din when the written word becomes the head,
   // otherwise from the next stored entry after a pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_nxt;
         end
         count <= count + CW'(push) - CW'(pop);
         if (push && ((count == CW'(0)) || ((count == CW'(1)) && pop))) begin
            dout <= din;
         end else if (pop && (count > CW'(1))) begin
            dout <= mem[rd_nxt];
         end
      end
   end

endmodule

// File: rtl/psoa_sigmoid_sym_stage.sv
// Signed wrapper around psoa_sigmoid: clamp |x|, track sign, apply f(-x) = 1 - f(x), buffer in a FIFO.
// Optional saturation counter port sat_count when PSOA_SAT_CNT_EN is defined.
module psoa_sigmoid_sym_stage
   import psoa_sigmoid_pkg::*;
#(
   parameter int       CORE_LAT = 1,
   parameter int       DEPTH    = 4,
   parameter fix16_u_t MAX_ABS  = MAX_ABS_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_f
`ifdef PSOA_SAT_CNT_EN
   ,
   output logic [15:0] sat_count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SB = CORE_LAT + 1;

   // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping.
   function automatic logic [16:0] abs17(input fix16_s_t x);
      logic [16:0] wide;
      wide = {x[15], x};
      return x[15] ? (17'd0 - wide) : wide;
   endfunction

   function automatic fix16_u_t clamp_mag(input logic [16:0] m);
      return (m > {1'b0, MAX_ABS}) ? MAX_ABS : m[15:0];
   endfunction

   function automatic fix16_u_t sym_fix(input fix16_u_t f, input logic neg);
      if (neg) begin
         return (f >= ONE_Q10) ? 16'd0 : (ONE_Q10 - f);
      end
      return (f > ONE_Q10) ? ONE_Q10 : f;
   endfunction

   logic          accept;
   logic [16:0]   in_abs;
   fix16_u_t      in_mag;
   fix16_u_t      x_reg;
   fix16_u_t      f_x;
   logic [SB-1:0] vld_sb;
   logic [SB-1:0] sgn_sb;
   logic          push;
   logic          pop;
   fix16_u_t      r_tail;
   logic [CW-1:0] count;
   int            occ_next;
   logic          ready_next;

   assign accept = in_valid & in_ready;
   assign in_abs = abs17(in_x);
   assign in_mag = clamp_mag(in_abs);

   // Input stage: clamped magnitude drives the core directly
   always_ff @(posedge clk) begin
      if (accept) begin
         x_reg <= in_mag;
      end
   end

   psoa_sigmoid #(
      .LAT(CORE_LAT)
   ) u_core (
      .x  (x_reg),
      .clk(clk),
      .f_x(f_x)
   );

   // Credit check on next-state occupancy so the registered in_ready is exact each cycle.
   always_comb begin
      occ_next   = int'(count) + int'(push) - int'(pop) + int'(accept)
                 + $countones(vld_sb[SB-2:0]);
      ready_next = (occ_next < DEPTH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_sb   <= '0;
         sgn_sb   <= '0;
         in_ready <= 1'b0;
      end else begin
         vld_sb   <= {vld_sb[SB-2:0], accept};
         sgn_sb   <= {sgn_sb[SB-2:0], accept & in_x[15]};
         in_ready <= ready_next;
      end
   end

   // Tail stage: sideband is aligned with f_x here
   assign push   = vld_sb[SB-1];
   assign r_tail = sym_fix(f_x, sgn_sb[SB-1]);

   assign out_valid = (count != CW'(0));
   assign pop       = out_valid & out_ready;

   psoa_sym_fifo #(
      .WIDTH(16),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (push),
      .pop    (pop),
      .din    (r_tail),
      .dout   (out_f),
      .count  (count)
   );

`ifdef PSOA_SAT_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sat_count <= '0;
      end else if (accept && (in_abs > {1'b0, MAX_ABS}) && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end
`endif

endmodule
